// File: rtl/keccak_round_ctrl.sv
// keccak_round_ctrl: shares one Keccak-f[1600] round engine between two
// requesters (0: SHAKE128 matrix expansion, 1: SHAKE256 sampling/hashing).
// Round-robin arbitration; drives the state-load strobe, per-cycle round
// enable and RC ROM base address, then pulses done to the owner.
//
// Optional build macro: KECCAK_ROUND_CTRL_PERF_EN
//   defined   -> perm_cnt counts completed permutations (saturating)
//   undefined -> perm_cnt is tied to zero
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | engine free, waiting for any req
// LOAD  | one cycle, datapath captures the owner's state
// ROUND | NR/UR cycles, UR rounds applied per cycle
// DONE  | one cycle, done[owner] pulses, re-arbitrate for back-to-back

module keccak_round_ctrl #(
  parameter int UR = 1,
  parameter int NR = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  output logic [1:0]  gnt,
  output logic        sel,
  output logic        perm_load,
  output logic        round_en,
  output logic [4:0]  rc_addr,
  output logic        last_round,
  output logic [1:0]  done,
  output logic        busy,
  output logic [31:0] perm_cnt
);

  // The RC ROM and round schedule only exist for the 24-round permutation.
  if (NR != 24) begin : g_bad_nr
    $error("keccak_round_ctrl: NR must be 24");
  end
  if ((UR < 1) || (UR > NR) || ((NR % UR) != 0)) begin : g_bad_ur
    $error("keccak_round_ctrl: UR must divide NR");
  end

  localparam logic [4:0] RC_STEP = 5'(UR);
  localparam logic [4:0] RC_LAST = 5'(NR - UR);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [4:0]  rc_q, rc_d;
  logic        perm_load_q, perm_load_d;
  logic        round_en_q, round_en_d;
  logic        last_round_q, last_round_d;
  logic [1:0]  done_q, done_d;
  logic        busy_q;
  logic [1:0]  owner_oh;
  logic [1:0]  cand;
  logic        win;

  assign owner_oh = owner_q ? 2'b10 : 2'b01;

  // State, owner, round-robin pointer and all registered outputs.
  // last_q resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_q       <= 1'b1;
      rc_q         <= 5'd0;
      perm_load_q  <= 1'b0;
      round_en_q   <= 1'b0;
      last_round_q <= 1'b0;
      done_q       <= 2'b00;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      rc_q         <= rc_d;
      perm_load_q  <= perm_load_d;
      round_en_q   <= round_en_d;
      last_round_q <= last_round_d;
      done_q       <= done_d;
      busy_q       <= (state_d != IDLE);
    end
  end

  // Next state and next-cycle output values; arbitration happens in IDLE
  // and in DONE, where the finishing owner's req is masked out.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    rc_d         = 5'd0;
    perm_load_d  = 1'b0;
    round_en_d   = 1'b0;
    last_round_d = 1'b0;
    done_d       = 2'b00;
    cand         = 2'b00;
    win          = 1'b0;
    case (state_q)
      IDLE: cand = req;
      LOAD: begin
        state_d      = ROUND;
        round_en_d   = 1'b1;
        last_round_d = (RC_LAST == 5'd0);
      end
      ROUND: begin
        if (rc_q == RC_LAST) begin
          state_d = DONE;
          done_d  = owner_oh;
        end else begin
          rc_d         = rc_q + RC_STEP;
          round_en_d   = 1'b1;
          last_round_d = ((rc_q + RC_STEP) == RC_LAST);
        end
      end
      DONE: begin
        state_d = IDLE;
        cand    = req & ~owner_oh;
      end
      default: state_d = IDLE;
    endcase
    if (cand != 2'b00) begin
      win         = (cand == 2'b11) ? ~last_q : cand[1];
      state_d     = LOAD;
      owner_d     = win;
      last_d      = win;
      perm_load_d = 1'b1;
    end
  end

  assign gnt        = busy_q ? owner_oh : 2'b00;
  assign sel        = owner_q;
  assign perm_load  = perm_load_q;
  assign round_en   = round_en_q;
  assign rc_addr    = rc_q;
  assign last_round = last_round_q;
  assign done       = done_q;
  assign busy       = busy_q;

`ifdef KECCAK_ROUND_CTRL_PERF_EN
  logic [31:0] perm_cnt_q;

  // Saturating count of completed permutations; cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perm_cnt_q <= 32'd0;
    end else if ((state_q == DONE) && (perm_cnt_q != 32'hFFFF_FFFF)) begin
      perm_cnt_q <= perm_cnt_q + 32'd1;
    end
  end

  assign perm_cnt = perm_cnt_q;
`else
  assign perm_cnt = 32'd0;
`endif

endmodule
